// File: rtl/spike_aer_pkg.sv
// -----------------------------------------------------------------------------
// spike_aer_pkg
// Shared types and constants for the spike AER arbiter and its round-robin
// picker.
//   state_e    : arbiter output FSM states (IDLE, SEND)
//   addr_w()   : ceil(log2(n)), never less than 1
//   DEF_DROP_W : default drop counter width
//   DEF_TS_W   : default timestamp width (used only with SPIKE_AER_TS_EN)
// -----------------------------------------------------------------------------
package spike_aer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_DROP_W = 8;
  localparam int DEF_TS_W   = 16;

  // Address width for n channels; a single channel still needs one bit.
  function automatic int addr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spike_aer_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin picker. Returns the first set bit of
// pending_i scanning rr_ptr_i+1, rr_ptr_i+2, ... with wrap modulo NUM_CH, so
// the most recently served channel has the lowest priority.
// Ports:
//   pending_i      [NUM_CH-1:0]  request vector
//   rr_ptr_i       [ADDR_W-1:0]  last served index (must be < NUM_CH)
//   any_pending_o                at least one request present
//   pick_o         [ADDR_W-1:0]  selected index (0 when nothing pending)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 3
) (
  input  logic [NUM_CH-1:0] pending_i,
  input  logic [ADDR_W-1:0] rr_ptr_i,
  output logic              any_pending_o,
  output logic [ADDR_W-1:0] pick_o
);

  int              cand;
  logic [NUM_CH-1:0] shifted;

  // Scan from the farthest candidate down to the nearest; the last hit
  // written is therefore the first one in round-robin order.
  always_comb begin
    any_pending_o = 1'b0;
    pick_o        = '0;
    cand          = 0;
    shifted       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand    = (int'(rr_ptr_i) + k) % NUM_CH;
      shifted = pending_i >> cand;
      if (shifted[0]) begin
        any_pending_o = 1'b1;
        pick_o        = ADDR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spike_aer_arbiter.sv
// -----------------------------------------------------------------------------
// spike_aer_arbiter
// Latches single-cycle spike pulses from NUM_CH channels, picks pending
// channels round-robin and emits one event address at a time on a
// valid/ready AER bus. Spikes arriving while a channel's pending slot is
// still full are counted in a saturating drop counter.
// Optional feature macro: SPIKE_AER_TS_EN adds a free-running timestamp
// counter and the aer_ts output, captured on every load.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      1 = new grants allowed; 0 = pending held, no new loads
//   spike_in    [NUM_CH-1:0] per-channel spike pulses
//   aer_valid   event address valid
//   aer_addr    [ADDR_W-1:0] channel index of the current event
//   aer_ready   downstream accept
//   busy        any pending bit set, or aer_valid high
//   drop_count  [DROP_W-1:0] saturating dropped-spike count
//   aer_ts      [TS_W-1:0] event timestamp (SPIKE_AER_TS_EN only)
// -----------------------------------------------------------------------------
module spike_aer_arbiter
  import spike_aer_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DROP_W = DEF_DROP_W
`ifdef SPIKE_AER_TS_EN
  , parameter int TS_W = DEF_TS_W
`endif
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_CH-1:0]                 spike_in,
  output logic                              aer_valid,
  output logic [spike_aer_pkg::addr_w(NUM_CH)-1:0] aer_addr,
  input  logic                              aer_ready,
  output logic                              busy,
  output logic [DROP_W-1:0]                 drop_count
`ifdef SPIKE_AER_TS_EN
  , output logic [TS_W-1:0]                 aer_ts
`endif
);

  localparam int ADDR_W = addr_w(NUM_CH);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [ADDR_W-1:0]   rr_ptr_q;
  logic                aer_valid_q, aer_valid_d;
  logic [ADDR_W-1:0]   aer_addr_q;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                any_pending;
  logic [ADDR_W-1:0]   pick;
  logic                handshake;
  logic                load;
  logic [NUM_CH-1:0]   load_mask;
  logic [NUM_CH-1:0]   drop_vec;
  logic [7:0]          drop_cnt;
  logic [DROP_W+7:0]   drop_sum;

  // Picker sees pending as registered: a spike in the current cycle is not
  // eligible until it has been latched.
  rr_picker #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_picker (
    .pending_i     (pending_q),
    .rr_ptr_i      (rr_ptr_q),
    .any_pending_o (any_pending),
    .pick_o        (pick)
  );

  assign handshake = aer_valid_q & aer_ready;

  // Output FSM: a load happens from IDLE, or from SEND on the handshake
  // cycle so that back-to-back events run at one per clock.
  always_comb begin
    state_d     = state_q;
    aer_valid_d = aer_valid_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_pending) begin
          load        = 1'b1;
          aer_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (enable && any_pending) begin
            load = 1'b1;
          end else begin
            aer_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        aer_valid_d = 1'b0;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign load_mask[gi] = load && (pick == ADDR_W'(gi));
  end

  // A new spike on the channel being loaded re-arms it rather than dropping.
  assign pending_d = (pending_q & ~load_mask) | spike_in;
  assign drop_vec  = spike_in & pending_q & ~load_mask;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_cnt = drop_cnt + {7'd0, drop_vec[i]};
    end
  end

  // Extra headroom bits catch overflow for saturation.
  assign drop_sum = {8'd0, drop_q} + {{DROP_W{1'b0}}, drop_cnt};
  assign drop_d   = (drop_sum[DROP_W+7:DROP_W] != 8'd0) ? {DROP_W{1'b1}}
                                                        : drop_sum[DROP_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= ADDR_W'(NUM_CH - 1);
      aer_valid_q <= 1'b0;
      aer_addr_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      aer_valid_q <= aer_valid_d;
      drop_q      <= drop_d;
      if (load) begin
        aer_addr_q <= pick;
        rr_ptr_q   <= pick;
      end
    end
  end

`ifdef SPIKE_AER_TS_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] aer_ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      aer_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (load) begin
        aer_ts_q <= ts_cnt_q;
      end
    end
  end

  assign aer_ts = aer_ts_q;
`else
  // No timestamp counter in this build.
`endif

  assign aer_valid  = aer_valid_q;
  assign aer_addr   = aer_addr_q;
  assign busy       = (|pending_q) | aer_valid_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
module tb_spike_aer_arbiter;

  localparam int NUM_CH = 4;
  localparam int DROP_W = 8;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] spike_in;
  logic              aer_valid;
  logic [1:0]        aer_addr;
  logic              aer_ready;
  logic              busy;
  logic [DROP_W-1:0] drop_count;

  int vectors;
  int miscompares;
  int exp_q[$];
  int n_cyc;

  spike_aer_arbiter #(
    .NUM_CH (NUM_CH),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .aer_valid  (aer_valid),
    .aer_addr   (aer_addr),
    .aer_ready  (aer_ready),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every handshake pops the next expected address.
  always @(negedge clk) begin
    int e;
    if (!reset && aer_valid === 1'b1 && aer_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected: got addr=%0d, expected no event", aer_addr);
      end else begin
        e = exp_q.pop_front();
        if (int'(aer_addr) != e) begin
          miscompares++;
          $display("FAIL event_addr: got %0d, expected %0d", aer_addr, e);
        end else begin
          $display("event addr=%0d ok", aer_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic drain(input int bound, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    spike_in  = '0;
    enable    = 1'b1;
    aer_ready = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    enable      = 1'b1;
    aer_ready   = 1'b1;
    spike_in    = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", int'(aer_valid), 0);
    chk("rst_addr", int'(aer_addr), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_busy", int'(busy), 0);
    tick();
    tick();
    reset = 1'b0;

    // Latency: spike in cycle t, valid from edge t+2, gone at t+3.
    spike_in = 4'b0100;
    exp_q.push_back(2);
    tick();
    spike_in = '0;
    chk("lat_valid_t1", int'(aer_valid), 0);
    chk("lat_busy_t1", int'(busy), 1);
    tick();
    chk("lat_valid_t2", int'(aer_valid), 1);
    chk("lat_addr_t2", int'(aer_addr), 2);
    tick();
    chk("lat_valid_t3", int'(aer_valid), 0);
    chk("lat_busy_t3", int'(busy), 0);
    chk("lat_drop", int'(drop_count), 0);

    // Round-robin burst after reset: 0,1,2,3 back to back.
    do_reset();
    spike_in = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick();
    spike_in = '0;
    drain(20, n_cyc);
    chk("burst_cycles", n_cyc, 5);
    chk("burst_valid_end", int'(aer_valid), 0);
    chk("burst_busy_end", int'(busy), 0);

    // Backpressure: addr 1 held, ch3 spike during stall follows.
    do_reset();
    aer_ready = 1'b0;
    spike_in  = 4'b0010;
    exp_q.push_back(1);
    tick();
    spike_in = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        spike_in = 4'b1000;
        exp_q.push_back(3);
      end else begin
        spike_in = '0;
      end
      chk("stall_valid", int'(aer_valid), 1);
      chk("stall_addr", int'(aer_addr), 1);
      tick();
    end
    spike_in  = '0;
    aer_ready = 1'b1;
    drain(20, n_cyc);

    // Drops: ch1 stalls the bus, ch0 spikes three times -> 2 drops.
    do_reset();
    aer_ready = 1'b0;
    spike_in  = 4'b0010;
    exp_q.push_back(1);
    tick();
    spike_in = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      spike_in = 4'b0001;
      tick();
      spike_in = '0;
      tick();
    end
    exp_q.push_back(0);
    chk("drop_two", int'(drop_count), 2);
    chk("drop_busy", int'(busy), 1);
    aer_ready = 1'b1;
    drain(20, n_cyc);
    chk("drop_two_after", int'(drop_count), 2);

    // Saturation: all channels spiking while stalled (well over 300 drops).
    aer_ready = 1'b0;
    spike_in  = 4'b1111;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(1);
    repeat (100) tick();
    chk("drop_sat", int'(drop_count), 255);
    spike_in  = '0;
    aer_ready = 1'b1;
    drain(20, n_cyc);
    chk("drop_sat_hold", int'(drop_count), 255);

    // Same-cycle set and clear on ch2: two events, no drop.
    do_reset();
    spike_in = 4'b0100;
    exp_q.push_back(2);
    exp_q.push_back(2);
    tick();
    tick();
    spike_in = '0;
    drain(20, n_cyc);
    chk("setclr_drop", int'(drop_count), 0);

    // Enable gating.
    do_reset();
    enable   = 1'b0;
    spike_in = 4'b0011;
    tick();
    spike_in = '0;
    repeat (3) tick();
    chk("en0_valid", int'(aer_valid), 0);
    chk("en0_busy", int'(busy), 1);
    enable = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    drain(20, n_cyc);
    chk("en1_busy", int'(busy), 0);

    // enable dropped during SEND: current event completes, no new load.
    aer_ready = 1'b0;
    spike_in  = 4'b0011;
    exp_q.push_back(0);
    tick();
    spike_in = '0;
    tick();
    enable    = 1'b0;
    aer_ready = 1'b1;
    tick();
    chk("ensend_valid", int'(aer_valid), 0);
    chk("ensend_busy", int'(busy), 1);
    chk("ensend_left", exp_q.size(), 0);
    enable = 1'b1;
    exp_q.push_back(1);
    drain(20, n_cyc);

    // Asynchronous reset in the middle of SEND.
    aer_ready = 1'b0;
    spike_in  = 4'b1111;
    tick();
    spike_in = '0;
    tick();
    chk("mid_valid_pre", int'(aer_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_valid_rst", int'(aer_valid), 0);
    chk("mid_busy_rst", int'(busy), 0);
    chk("mid_addr_rst", int'(aer_addr), 0);
    chk("mid_drop_rst", int'(drop_count), 0);
    exp_q.delete();
    tick();
    reset     = 1'b0;
    aer_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
